// File: rtl/mont_mult_iter.sv
// Word-serial Montgomery multiplier: o_dat = a*b*2^-DAT_BITS mod P, one word of a per cycle.
// Operands and tag are captured on the input handshake; the result is held until the output handshake.
//
// state   | meaning
// S_IDLE  | ready for operands
// S_MUL   | one reduction step per word of a, LS word first
// S_FINAL | conditional subtract of P, load result registers
// S_DONE  | result valid, waiting for downstream
module mont_mult_iter #(
  parameter int                  DAT_BITS    = 256,
  parameter int                  WORD_BITS   = 64,
  parameter logic [DAT_BITS-1:0] P           = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  parameter logic [DAT_BITS-1:0] MONT_FACTOR = 256'hf57a22b791888c6bd8afcbd01833da809ede7d651eca6ac987d20782e4866389,
  parameter int                  CTL_BITS    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_val,
  output logic                o_rdy,
  input  logic [DAT_BITS-1:0] i_dat_a,
  input  logic [DAT_BITS-1:0] i_dat_b,
  input  logic [CTL_BITS-1:0] i_ctl,
  output logic                o_val,
  input  logic                i_rdy,
  output logic [DAT_BITS-1:0] o_dat,
  output logic [CTL_BITS-1:0] o_ctl
);

  localparam int NW = DAT_BITS / WORD_BITS;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int TW = DAT_BITS + 2;
  localparam int XW = DAT_BITS + WORD_BITS + 2;
  localparam logic [WORD_BITS-1:0] NP = MONT_FACTOR[WORD_BITS-1:0];

  if (DAT_BITS % WORD_BITS != 0) begin : g_bad_word
    $fatal(1, "mont_mult_iter: DAT_BITS must be a multiple of WORD_BITS");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FINAL, S_DONE} state_t;

  state_t              state, state_next;
  logic [DAT_BITS-1:0] a_reg, b_reg;
  logic [CTL_BITS-1:0] ctl_reg;
  logic [TW-1:0]       t_reg, t_next;
  logic [CW-1:0]       cnt;
  logic [WORD_BITS-1:0] a_word, m_word;
  logic [XW-1:0]       t1, t2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_rdy      = 1'b0;
    case (state)
      S_IDLE: begin
        o_rdy = 1'b1;
        if (i_val) state_next = S_MUL;
      end
      S_MUL:   if (cnt == CW'(NW - 1)) state_next = S_FINAL;
      S_FINAL: state_next = S_DONE;
      S_DONE:  if (i_rdy) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Full-width intermediate: T < 2P plus a_i*b and m*P needs DAT+WORD+2 bits before the shift.
  always_comb begin
    a_word = a_reg[WORD_BITS-1:0];
    t1     = XW'(t_reg) + XW'(a_word) * XW'(b_reg);
    m_word = t1[WORD_BITS-1:0] * NP;
    t2     = t1 + XW'(m_word) * XW'(P);
    t_next = TW'(t2 >> WORD_BITS);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      ctl_reg <= '0;
      t_reg   <= '0;
      cnt     <= '0;
      o_val   <= 1'b0;
      o_dat   <= '0;
      o_ctl   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_val) begin
            a_reg   <= i_dat_a;
            b_reg   <= i_dat_b;
            ctl_reg <= i_ctl;
            t_reg   <= '0;
            cnt     <= '0;
          end
        end
        S_MUL: begin
          t_reg <= t_next;
          a_reg <= a_reg >> WORD_BITS;
          cnt   <= cnt + CW'(1);
        end
        S_FINAL: begin
          o_dat <= DAT_BITS'((t_reg >= TW'(P)) ? (t_reg - TW'(P)) : t_reg);
          o_ctl <= ctl_reg;
          o_val <= 1'b1;
        end
        S_DONE: begin
          if (i_rdy) o_val <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mont_mult_iter.md
Name: mont_mult_iter

Overview:
- Word-serial (radix-2^WORD_BITS) Montgomery multiplier. Computes o_dat = a*b*2^(-DAT_BITS) mod P, one multiplier word per cycle.
- Parametrised successor of the fixed 256-bit single-shot Montgomery multiply used in the bn128 model. Width, word size, modulus and constants are generic, with a valid/ready handshake and a control-tag sideband.
- Sits under the G1/G2 point add/double cores as their Fp multiply primitive. The bn128 model function is the golden reference.

Parameters:
- DAT_BITS, 256: operand/result width; Montgomery R = 2^DAT_BITS.
- WORD_BITS, 64: digit width consumed per cycle; DAT_BITS % WORD_BITS must be 0 (elaboration $fatal otherwise).
- P, bn128 modulus: odd prime, P < 2^DAT_BITS.
- MONT_FACTOR, 256'hf57a...6389: -P^-1 mod 2^DAT_BITS; only the low WORD_BITS bits (NP) are used.
- CTL_BITS, 8: sideband tag width.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_val, input, 1: input operands valid.
- o_rdy, output, 1: block can accept operands.
- i_dat_a, input, DAT_BITS: operand a, Montgomery form, < P.
- i_dat_b, input, DAT_BITS: operand b, Montgomery form, < P.
- i_ctl, input, CTL_BITS: tag captured with operands.
- o_val, output, 1: result valid.
- i_rdy, input, 1: downstream accepts result.
- o_dat, output, DAT_BITS: result, < P.
- o_ctl, output, CTL_BITS: tag from the accepted input.

Behaviour:
- NW = DAT_BITS/WORD_BITS.
- Reset state: IDLE. o_rdy=1, o_val=0, o_dat=0, o_ctl=0, accumulator T=0, word counter=0.
- States: IDLE -> MUL -> FINAL -> DONE -> IDLE.
- IDLE:
  - o_rdy=1.
  - When i_val&&o_rdy: capture a, b, ctl; clear T; counter=0; go to MUL.
- MUL, one cycle per word i = 0..NW-1:
  - a_i = word i of a, LS word first.
  - T1 = T + a_i*b.
  - m = (T1[WORD_BITS-1:0]*NP) mod 2^WORD_BITS.
  - T = (T1 + m*P) >> WORD_BITS.
  - After i = NW-1, go to FINAL.
- Width rule: T is held in DAT_BITS+2 bits (invariant T < 2P). Intermediate T1 + m*P is DAT_BITS+WORD_BITS+2 bits, with no truncation before the shift.
- FINAL:
  - o_dat = (T >= P) ? T-P : T; o_ctl = captured tag.
  - o_val asserts on the next edge; go to DONE.
- DONE:
  - o_val=1; o_dat and o_ctl held stable until i_rdy.
  - On o_val&&i_rdy: o_val=0 next cycle, go to IDLE.
- Latency: handshake edge to o_val high = NW+1 cycles (5 for 256/64). Throughput is one result per NW+3 cycles minimum.
- o_rdy=0 in MUL, FINAL and DONE. i_val in those states is ignored and the operands are not captured.
- Operand a=0 or b=0 gives 0. b=1 gives a*R^-1 (from-Montgomery conversion).
- Reset asserted mid-operation: all state returns to reset values immediately. No partial result is emitted after release.
- i_rdy high before o_val has no effect. o_val never drops without a handshake.
- Inputs >= P are out of contract; the result is unspecified but < 2^DAT_BITS, and the FSM must still complete.

Test Plan:
- To-Montgomery conversion:
  - Stimulus: a=1, b=MONT_RECIP_SQ (256'h06d8...afa89), ctl=8'h5A.
  - Required response: o_dat = 256'h0e0a77c19a07df2f666ea36f7879462c0a78eb28f5c70b3dd35d438dc58f0d9d (R mod P); o_ctl=8'h5A; o_val exactly 5 cycles after the handshake.
- Montgomery one times one:
  - Stimulus: a = b = R mod P (value above).
  - Required response: o_dat = R mod P.
- From-Montgomery conversion:
  - Stimulus: a = R mod P, b = 1.
  - Required response: o_dat = 1.
  - Stimulus: a=0, b=P-1.
  - Required response: o_dat = 0.
- Backpressure:
  - Stimulus: hold i_rdy=0 for 6 cycles after o_val; drive i_val=1 with new operands throughout.
  - Required response: o_val, o_dat, o_ctl stable; o_rdy=0; the second operand pair is accepted only after return to IDLE.
- Reset mid-operation:
  - Stimulus: drop i_rst_n in MUL cycle 2.
  - Required response: o_val=0, o_rdy=1 immediately. A fresh op after release returns the correct value with no stale output.
- Random regression:
  - Stimulus: 2000 random a, b < P with random i_val/i_rdy gaps, at WORD_BITS=64 and WORD_BITS=32.
  - Required response: every result matches the bn128 fe_mul_mont model; tags stay in order with no drop or duplication.
